// File: rtl/mem_access_unit_if.sv
// Data-memory port between the MEM-stage access unit and the data memory.
//   master (mem_access_unit): drives mem_req, mem_we, mem_addr, mem_wdata,
//                             mem_wmask; samples mem_ack, mem_rdata
//   slave  (memory)         : the mirror image
// Handshake: mem_req is raised by the master and held high, together with
// stable mem_we/mem_addr/mem_wdata/mem_wmask, until the cycle in which the
// slave pulses mem_ack for one cycle; read data is valid in that same cycle.
// An ack while mem_req is low carries no meaning and is ignored.
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit. Decodes loads/stores from the EX/MEM register,
// runs a req/ack access on the data-memory port, aligns/masks store data,
// extracts and extends load data, and registers results into MEM/WB.
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   pc_mem..valid_mem   EX/MEM pipeline register outputs
//   stall_mem           combinational hold for EX/MEM and earlier stages
//   mem                 data-memory port (master side)
//   *_wb                MEM/WB pipeline register outputs
//   dbg_state_o         current FSM state (1 = WAIT)
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [63:0]         pc_mem,
  input  logic [31:0]         inst_mem,
  input  logic [23:0]         sign_mem,
  input  logic [63:0]         alu_result_mem,
  input  logic [63:0]         store_data_mem,
  input  logic                valid_mem,
  output logic                stall_mem,
  mem_access_unit_if.master   mem,
  output logic [63:0]         pc_wb,
  output logic [31:0]         inst_wb,
  output logic [23:0]         sign_wb,
  output logic [63:0]         alu_result_wb,
  output logic [63:0]         load_data_wb,
  output logic                fault_wb,
  output logic                valid_wb,
  output logic                dbg_state_o
);

  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic        req_q, we_q;
  logic [63:0] addr_q, wdata_q;
  logic [7:0]  wmask_q;
  logic [63:0] pc_q, alu_q, ld_q;
  logic [31:0] inst_q;
  logic [23:0] sign_q;
  logic        fault_q, valid_q;

  logic [2:0]  funct3, off;
  logic        is_load, is_store, memop, illegal, misaligned, bad;
  logic        timeout_hit, wait_done;
  logic [63:0] st_wdata, lane, ld_ext;
  logic [7:0]  st_wmask;

  assign funct3   = inst_mem[14:12];
  assign off      = alu_result_mem[2:0];
  assign is_load  = valid_mem & (inst_mem[6:0] == OP_LOAD);
  assign is_store = valid_mem & (inst_mem[6:0] == OP_STORE);
  assign memop    = is_load | is_store;

  // funct3[1:0] encodes log2(size) for every legal load/store.
  always_comb begin
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00: misaligned = 1'b0;
      2'b01: misaligned = off[0];
      2'b10: misaligned = |off[1:0];
      2'b11: misaligned = |off;
      default: misaligned = 1'b0;
    endcase
  end

  assign illegal     = is_load ? (funct3 == 3'b111) : (is_store & funct3[2]);
  assign bad         = memop & (illegal | misaligned);
  assign timeout_hit = (state_q == S_WAIT) & ~mem.mem_ack & (cnt_q == TO_LAST);
  assign wait_done   = (state_q == S_WAIT) & (mem.mem_ack | timeout_hit);
  assign stall_mem   = memop & ~bad & ~wait_done;

  // Store lane replication; the mask selects the addressed bytes.
  always_comb begin
    st_wdata = store_data_mem;
    st_wmask = 8'h00;
    case (funct3[1:0])
      2'b00: begin st_wdata = {8{store_data_mem[7:0]}};  st_wmask = 8'h01 << off; end
      2'b01: begin st_wdata = {4{store_data_mem[15:0]}}; st_wmask = 8'h03 << off; end
      2'b10: begin st_wdata = {2{store_data_mem[31:0]}}; st_wmask = 8'h0F << off; end
      2'b11: begin st_wdata = store_data_mem;            st_wmask = 8'hFF;        end
      default: ;
    endcase
  end

  // Shift the addressed bytes down to bit 0, then extend by funct3.
  assign lane = mem.mem_rdata >> {off, 3'b000};
  always_comb begin
    ld_ext = 64'h0;
    case (funct3)
      3'b000: ld_ext = {{56{lane[7]}},  lane[7:0]};
      3'b001: ld_ext = {{48{lane[15]}}, lane[15:0]};
      3'b010: ld_ext = {{32{lane[31]}}, lane[31:0]};
      3'b011: ld_ext = lane;
      3'b100: ld_ext = {56'h0, lane[7:0]};
      3'b101: ld_ext = {48'h0, lane[15:0]};
      3'b110: ld_ext = {32'h0, lane[31:0]};
      default: ld_ext = 64'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'h0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 64'h0;
      wdata_q <= 64'h0;
      wmask_q <= 8'h00;
      pc_q    <= 64'h0;
      inst_q  <= 32'h0;
      sign_q  <= 24'h0;
      alu_q   <= 64'h0;
      ld_q    <= 64'h0;
      fault_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (memop & ~bad) begin
            state_q <= S_WAIT;
            req_q   <= 1'b1;
            we_q    <= is_store;
            addr_q  <= {alu_result_mem[63:3], 3'b000};
            wdata_q <= is_store ? st_wdata : 64'h0;
            wmask_q <= is_store ? st_wmask : 8'h00;
            cnt_q   <= 16'h0;
          end
        end
        S_WAIT: begin
          if (mem.mem_ack | timeout_hit) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 16'h1;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // MEM/WB register: a stall inserts a bubble and holds the payload.
      if (stall_mem) begin
        valid_q <= 1'b0;
      end else begin
        pc_q    <= pc_mem;
        inst_q  <= inst_mem;
        sign_q  <= sign_mem;
        alu_q   <= alu_result_mem;
        valid_q <= valid_mem;
        ld_q    <= ((state_q == S_WAIT) & mem.mem_ack & is_load) ? ld_ext : 64'h0;
        fault_q <= bad | (memop & timeout_hit);
      end
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wmask = wmask_q;
  assign pc_wb         = pc_q;
  assign inst_wb       = inst_q;
  assign sign_wb       = sign_q;
  assign alu_result_wb = alu_q;
  assign load_data_wb  = ld_q;
  assign fault_wb      = fault_q;
  assign valid_wb      = valid_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit (TIMEOUT=4).
module tb_mem_access_unit;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        clk, rst;
  logic [63:0] pc_mem, alu_result_mem, store_data_mem;
  logic [31:0] inst_mem;
  logic [23:0] sign_mem;
  logic        valid_mem, stall_mem;
  logic [63:0] pc_wb, alu_result_wb, load_data_wb;
  logic [31:0] inst_wb;
  logic [23:0] sign_wb;
  logic        fault_wb, valid_wb, dbg_state;
  int          n_tests, n_fail;

  mem_access_unit_if bus();

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .pc_mem(pc_mem), .inst_mem(inst_mem), .sign_mem(sign_mem),
    .alu_result_mem(alu_result_mem), .store_data_mem(store_data_mem),
    .valid_mem(valid_mem), .stall_mem(stall_mem), .mem(bus.master),
    .pc_wb(pc_wb), .inst_wb(inst_wb), .sign_wb(sign_wb),
    .alu_result_wb(alu_result_wb), .load_data_wb(load_data_wb),
    .fault_wb(fault_wb), .valid_wb(valid_wb), .dbg_state_o(dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] sd, input logic v);
    inst_mem       = {17'h0, f3, 5'h0, op};
    alu_result_mem = addr;
    store_data_mem = sd;
    pc_mem         = 64'h8000_0000 + addr;
    sign_mem       = 24'hA5A5A5;
    valid_mem      = v;
  endtask

  task automatic idle_inputs();
    valid_mem     = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 64'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    drive(OP_ALU, 3'b000, 64'h0, 64'h0, 1'b0);
    tick(); tick();
    n_tests++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", bus.mem_req); end
    n_tests++; if (bus.mem_wmask !== 8'h00) begin n_fail++; $display("FAIL reset_wmask got %h exp 00", bus.mem_wmask); end
    n_tests++; if (valid_wb !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", valid_wb); end
    n_tests++; if (pc_wb !== 64'h0) begin n_fail++; $display("FAIL reset_pc_wb got %h exp 0", pc_wb); end
    n_tests++; if (stall_mem !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall_mem); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lb_lbu();
    logic [2:0]  f3s [2];
    logic [63:0] exps [2];
    f3s  = '{3'b000, 3'b100};
    exps = '{64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_0080};
    for (int i = 0; i < 2; i++) begin
      drive(OP_LOAD, f3s[i], 64'h1003, 64'h0, 1'b1);
      #1;
      n_tests++; if (stall_mem !== 1'b1) begin n_fail++; $display("FAIL lb_stall_n%0d got %b exp 1", i, stall_mem); end
      tick();
      n_tests++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL lb_req%0d got %b exp 1", i, bus.mem_req); end
      n_tests++; if (bus.mem_addr !== 64'h1000) begin n_fail++; $display("FAIL lb_addr%0d got %h exp 1000", i, bus.mem_addr); end
      n_tests++; if (bus.mem_wmask !== 8'h00 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL lb_wmask_we%0d got %h/%b exp 00/0", i, bus.mem_wmask, bus.mem_we); end
      bus.mem_ack = 1'b1; bus.mem_rdata = 64'h0000_0000_8000_0000;
      #1;
      n_tests++; if (stall_mem !== 1'b0) begin n_fail++; $display("FAIL lb_stall_ack%0d got %b exp 0", i, stall_mem); end
      tick();
      idle_inputs();
      n_tests++; if (load_data_wb !== exps[i]) begin n_fail++; $display("FAIL lb_data%0d got %h exp %h", i, load_data_wb, exps[i]); end
      n_tests++; if (valid_wb !== 1'b1 || fault_wb !== 1'b0) begin n_fail++; $display("FAIL lb_valid_fault%0d got %b/%b exp 1/0", i, valid_wb, fault_wb); end
      n_tests++; if (pc_wb !== 64'h8000_1003) begin n_fail++; $display("FAIL lb_pc_wb%0d got %h exp 80001003", i, pc_wb); end
    end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3s [6];
    logic [63:0] addrs [6];
    logic [63:0] rds [6];
    logic [63:0] exps [6];
    f3s   = '{3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b000};
    addrs = '{64'h6004, 64'h6004, 64'h6006, 64'h6006, 64'h6000, 64'h6001};
    rds   = '{64'h8765_4321_0000_0000, 64'h8765_4321_0000_0000, 64'h8765_4321_0000_0000,
              64'h8765_4321_0000_0000, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567};
    exps  = '{64'hFFFF_FFFF_8765_4321, 64'h0000_0000_8765_4321, 64'hFFFF_FFFF_FFFF_8765,
              64'h0000_0000_0000_8765, 64'hDEAD_BEEF_0123_4567, 64'h0000_0000_0000_0045};
    for (int i = 0; i < 6; i++) begin
      drive(OP_LOAD, f3s[i], addrs[i], 64'h0, 1'b1);
      tick();
      for (int w = 0; w < i % 3; w++) begin
        n_tests++; if (stall_mem !== 1'b1 || valid_wb !== 1'b0) begin n_fail++; $display("FAIL ld_wait%0d got stall %b valid %b exp 1/0", i, stall_mem, valid_wb); end
        tick();
      end
      n_tests++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL ld_req%0d got %b exp 1", i, bus.mem_req); end
      bus.mem_ack = 1'b1; bus.mem_rdata = rds[i];
      tick();
      idle_inputs();
      n_tests++; if (load_data_wb !== exps[i]) begin n_fail++; $display("FAIL ld_data%0d got %h exp %h", i, load_data_wb, exps[i]); end
    end
  endtask

  task automatic test_store_sh();
    drive(OP_STORE, 3'b001, 64'h2006, 64'h1111_2222_3333_ABCD, 1'b1);
    tick();
    n_tests++; if (bus.mem_wdata !== 64'hABCD_ABCD_ABCD_ABCD) begin n_fail++; $display("FAIL sh_wdata got %h exp ABCDABCDABCDABCD", bus.mem_wdata); end
    n_tests++; if (bus.mem_wmask !== 8'hC0) begin n_fail++; $display("FAIL sh_wmask got %h exp C0", bus.mem_wmask); end
    n_tests++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 64'h2000) begin n_fail++; $display("FAIL sh_we_addr got %b/%h exp 1/2000", bus.mem_we, bus.mem_addr); end
    for (int w = 0; w < 2; w++) begin
      n_tests++; if (stall_mem !== 1'b1 || valid_wb !== 1'b0) begin n_fail++; $display("FAIL sh_wait got stall %b valid %b exp 1/0", stall_mem, valid_wb); end
      tick();
    end
    bus.mem_ack = 1'b1;
    #1;
    n_tests++; if (stall_mem !== 1'b0) begin n_fail++; $display("FAIL sh_stall_ack got %b exp 0", stall_mem); end
    tick();
    bus.mem_ack = 1'b0;
    n_tests++; if (valid_wb !== 1'b1 || load_data_wb !== 64'h0 || fault_wb !== 1'b0) begin n_fail++; $display("FAIL sh_wb got v%b d%h f%b exp 1/0/0", valid_wb, load_data_wb, fault_wb); end
    n_tests++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL sh_req_drop got %b exp 0", bus.mem_req); end
    // ALU op right behind the store, with a stray ack while mem_req is low.
    drive(OP_ALU, 3'b000, 64'h55, 64'h0, 1'b1);
    bus.mem_ack = 1'b1;
    #1;
    n_tests++; if (stall_mem !== 1'b0) begin n_fail++; $display("FAIL alu_stall got %b exp 0", stall_mem); end
    tick();
    idle_inputs();
    n_tests++; if (alu_result_wb !== 64'h55 || valid_wb !== 1'b1) begin n_fail++; $display("FAIL alu_wb got %h/%b exp 55/1", alu_result_wb, valid_wb); end
    n_tests++; if (bus.mem_req !== 1'b0 || fault_wb !== 1'b0 || load_data_wb !== 64'h0) begin n_fail++; $display("FAIL alu_ack_ignored got req %b f %b d %h exp 0/0/0", bus.mem_req, fault_wb, load_data_wb); end
    tick();
    n_tests++; if (valid_wb !== 1'b0) begin n_fail++; $display("FAIL alu_bubble got %b exp 0", valid_wb); end
  endtask

  task automatic test_store_lanes();
    logic [2:0]  f3s [3];
    logic [63:0] addrs [3];
    logic [63:0] sds [3];
    logic [63:0] expd [3];
    logic [7:0]  expm [3];
    f3s   = '{3'b000, 3'b010, 3'b011};
    addrs = '{64'h2005, 64'h2004, 64'h2000};
    sds   = '{64'h9999_9999_9999_995A, 64'h7777_7777_CAFE_F00D, 64'h0123_4567_89AB_CDEF};
    expd  = '{64'h5A5A_5A5A_5A5A_5A5A, 64'hCAFE_F00D_CAFE_F00D, 64'h0123_4567_89AB_CDEF};
    expm  = '{8'h20, 8'hF0, 8'hFF};
    for (int i = 0; i < 3; i++) begin
      drive(OP_STORE, f3s[i], addrs[i], sds[i], 1'b1);
      tick();
      n_tests++; if (bus.mem_wdata !== expd[i] || bus.mem_wmask !== expm[i]) begin n_fail++; $display("FAIL st_lane%0d got %h/%h exp %h/%h", i, bus.mem_wdata, bus.mem_wmask, expd[i], expm[i]); end
      bus.mem_ack = 1'b1;
      tick();
      idle_inputs();
    end
  endtask

  task automatic test_bad_ops();
    logic [6:0]  ops [3];
    logic [2:0]  f3s [3];
    logic [63:0] addrs [3];
    ops   = '{OP_LOAD, OP_STORE, OP_LOAD};
    f3s   = '{3'b010, 3'b100, 3'b111};
    addrs = '{64'h3002, 64'h4000, 64'h4008};
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], f3s[i], addrs[i], 64'h0, 1'b1);
      #1;
      n_tests++; if (stall_mem !== 1'b0) begin n_fail++; $display("FAIL bad_stall%0d got %b exp 0", i, stall_mem); end
      tick();
      idle_inputs();
      n_tests++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL bad_req%0d got %b exp 0", i, bus.mem_req); end
      n_tests++; if (fault_wb !== 1'b1 || valid_wb !== 1'b1 || load_data_wb !== 64'h0) begin n_fail++; $display("FAIL bad_wb%0d got f%b v%b d%h exp 1/1/0", i, fault_wb, valid_wb, load_data_wb); end
    end
    // Memory opcode with valid_mem low: no stall, no request.
    drive(OP_LOAD, 3'b011, 64'h5000, 64'h0, 1'b0);
    #1;
    n_tests++; if (stall_mem !== 1'b0) begin n_fail++; $display("FAIL novalid_stall got %b exp 0", stall_mem); end
    tick();
    n_tests++; if (bus.mem_req !== 1'b0 || valid_wb !== 1'b0) begin n_fail++; $display("FAIL novalid_req got %b/%b exp 0/0", bus.mem_req, valid_wb); end
  endtask

  task automatic test_timeout();
    drive(OP_LOAD, 3'b011, 64'h5000, 64'h0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_tests++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL to_req_c%0d got %b exp 1", k, bus.mem_req); end
      n_tests++; if (stall_mem !== (k == 4 ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL to_stall_c%0d got %b exp %b", k, stall_mem, (k != 4)); end
    end
    tick();
    idle_inputs();
    n_tests++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL to_req_drop got %b exp 0", bus.mem_req); end
    n_tests++; if (fault_wb !== 1'b1 || valid_wb !== 1'b1 || load_data_wb !== 64'h0) begin n_fail++; $display("FAIL to_wb got f%b v%b d%h exp 1/1/0", fault_wb, valid_wb, load_data_wb); end
  endtask

  task automatic test_reset_in_wait();
    drive(OP_LOAD, 3'b011, 64'h7000, 64'h0, 1'b1);
    for (int k = 0; k < 4; k++) tick();
    n_tests++; if (bus.mem_req !== 1'b1 || dbg_state !== 1'b1) begin n_fail++; $display("FAIL rw_pre got req %b st %b exp 1/1", bus.mem_req, dbg_state); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    valid_mem = 1'b0;
    n_tests++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rw_req got %b exp 0", bus.mem_req); end
    n_tests++; if (valid_wb !== 1'b0 || fault_wb !== 1'b0 || load_data_wb !== 64'h0 || pc_wb !== 64'h0) begin n_fail++; $display("FAIL rw_wb got v%b f%b d%h pc%h exp zeros", valid_wb, fault_wb, load_data_wb, pc_wb); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    n_tests++; if (stall_mem !== 1'b0) begin n_fail++; $display("FAIL rw_stall got %b exp 0", stall_mem); end
    tick();
    idle_inputs();
    n_tests++; if (valid_wb !== 1'b0 || load_data_wb !== 64'h0 || bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rw_late_ack got v%b d%h r%b exp 0/0/0", valid_wb, load_data_wb, bus.mem_req); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_lb_lbu();
    test_load_extend();
    test_store_sh();
    test_store_lanes();
    test_bad_ops();
    test_timeout();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage consumer of the EX/MEM pipeline register outputs. Decodes load/store from inst_mem, drives a req/ack data-memory port, and aligns, masks and sign-extends data. Stalls the front of the pipeline until the access completes, then registers results into the MEM/WB boundary. Non-memory instructions pass through with one-cycle latency.

Parameters:
TIMEOUT, 255, max cycles in WAIT before the access is abandoned with a fault (1..65535)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
pc_mem  in  64  PC from EX/MEM
inst_mem  in  32  instruction; opcode [6:0], funct3 [14:12]
sign_mem  in  24  control bundle, passed through untouched
alu_result_mem  in  64  effective byte address / ALU result
store_data_mem  in  64  rs2 value for stores
valid_mem  in  1  EX/MEM slot holds a live instruction
stall_mem  out  1  combinational; holds EX/MEM and earlier stages
mem_req  out  1  registered request, held high until ack
mem_we  out  1  1=store, 0=load; stable while mem_req
mem_addr  out  64  byte address with [2:0] cleared; stable while mem_req
mem_wdata  out  64  lane-replicated store data
mem_wmask  out  8  byte enables; 0 for loads
mem_ack  in  1  one-cycle completion pulse; rdata valid in the same cycle
mem_rdata  in  64  doubleword read data
pc_wb, inst_wb, sign_wb, alu_result_wb  out  64/32/24/64  registered pass-through
load_data_wb  out  64  extended load result; 0 for non-loads
fault_wb  out  1  misaligned, illegal funct3, or timeout
valid_wb  out  1  MEM/WB slot live

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, timeout counter=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0. All *_wb outputs are 0. Reset wins over every other event, including reset in WAIT: mem_req falls at the next edge, and a late ack is ignored.
- memop = valid_mem & (opcode==0000011 load | opcode==0100011 store).
- Legal funct3 values:
  - loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU
  - stores: 000–011
- Size is 1, 2, 4 or 8 bytes. Misaligned means addr[2:0] is not a multiple of size.
- bad = memop & (illegal funct3 | misaligned). A bad op issues no request and completes in one cycle with fault_wb=1 and load_data_wb=0.
- stall_mem = memop & ~bad & ~(state==WAIT & (mem_ack | timeout_hit)).
- State machine:
  - IDLE -> WAIT when memop & ~bad. Register mem_req=1, mem_we, mem_addr, mem_wdata, mem_wmask, and clear the counter.
  - WAIT -> IDLE on mem_ack. Drop mem_req and capture the result into WB.
  - WAIT -> IDLE on timeout_hit (counter==TIMEOUT-1 with no ack). Drop mem_req and set fault_wb=1.
  - WAIT otherwise: counter increments each cycle.
- mem_ack seen in IDLE is ignored.
- Minimum load/store latency: instruction present at cycle N, mem_req high from N+1. Ack at N+1 gives stall_mem low in N+1 and WB valid at N+2.
- Store lanes:
  - SB: wdata = byte replicated ×8, mask = 1<<a.
  - SH: half ×4, mask = 0x03<<a.
  - SW: word ×2, mask = 0x0F<<a.
  - SD: full 64 bits, mask = 0xFF.
  - a = addr[2:0].
- Load extract: select rdata[8a +: size*8], then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU/LD) to 64 bits.
- MEM/WB register, each edge:
  - if stall_mem: valid_wb<=0 (bubble), other *_wb hold.
  - else: capture pass-through fields, valid_wb<=valid_mem.
  - load_data_wb and fault_wb are computed as above; both are 0 for non-memory instructions.
- valid_mem=0 produces no request and no stall, regardless of opcode.

Test Plan:
- Reset in WAIT: issue LD, hold ack low 3 cycles, then rst=1 -> mem_req=0 and all *_wb=0 next cycle. Ack pulsed afterwards -> no WB capture, stall_mem=0.
- LB at 0x1003, rdata=0x0000_0000_8000_0000 after 0 wait -> mem_addr=0x1000, wmask=0x00. Ack at N+1 -> load_data_wb=0xFFFF_FFFF_FFFF_FF80 at N+2. LBU on the same data -> 0x80.
- SH at 0x2006, rs2=0x..._ABCD -> wdata=0xABCD_ABCD_ABCD_ABCD, wmask=0xC0, mem_we=1. stall_mem high until the ack cycle; valid_wb=0 during the wait.
- LW at 0x3002 (misaligned) -> no mem_req, stall_mem=0, next cycle fault_wb=1, valid_wb=1, load_data_wb=0.
- TIMEOUT=4, LD with ack never asserted -> mem_req high exactly 4 cycles, then fault_wb=1 and stall released.
- ALU op with alu_result=0x55 following a store -> passes to WB one cycle after the store completes; ack with mem_req low is ignored.
